// File: rtl/ame_pkg.sv
// Shared types and constants for the AME normal-equation builder.
// Accumulator slots cover the upper triangle of the symmetric 6x6 matrix A.
package ame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        ISSUE,
        WAIT
    } bld_state_t;

    localparam int AME_NUM_PARAM = 6;
    localparam int AME_NUM_COL   = 7;
    localparam int AME_NUM_TRI   = 21;

    // Maps pair (i,j), in either order, to its upper-triangle slot 0..20.
    function automatic int tri_slot(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * AME_NUM_PARAM - (lo * (lo - 1)) / 2 + (hi - lo);
    endfunction

endpackage

// File: rtl/ame_mac_cell.sv
// One multiply-accumulate lane: registered signed product, then sign-extended
// wrap-around accumulation. Synchronous clear drops any in-flight product.
module ame_mac_cell #(
    parameter int SMP_DATA_BITS  = 16,
    parameter int COMP_DATA_BITS = 64
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_en,
    input  logic                             i_clr,
    input  logic signed [SMP_DATA_BITS-1:0]  i_a,
    input  logic signed [SMP_DATA_BITS-1:0]  i_b,
    output logic [COMP_DATA_BITS-1:0]        o_acc
);

    localparam int PROD_BITS = 2 * SMP_DATA_BITS;

    logic signed [PROD_BITS-1:0]      r_prod;
    logic                             r_prod_vld;
    logic signed [COMP_DATA_BITS-1:0] r_acc;
    logic signed [PROD_BITS-1:0]      w_prod;
    logic signed [COMP_DATA_BITS-1:0] w_ext;

    assign w_prod = PROD_BITS'(i_a) * PROD_BITS'(i_b);
    assign w_ext  = COMP_DATA_BITS'(r_prod);
    assign o_acc  = r_acc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else if (i_clr) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_prod_vld <= i_en;
            if (i_en) begin
                r_prod <= w_prod;
            end
            if (r_prod_vld) begin
                r_acc <= r_acc + w_ext;
            end
        end
    end

endmodule

// File: rtl/ame_equation_builder.sv
// Accumulates gradient samples into the 6x7 normal-equation matrix [A|B] for one
// block, hands it to the solver with a start pulse and clears once it reports done.
module ame_equation_builder
    import ame_pkg::*;
#(
    parameter int SMP_DATA_BITS  = 16,
    parameter int COMP_DATA_BITS = 64,
    parameter int SMP_CNT_BITS   = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         affine_param6_i,
    input  logic                                         smp_valid_i,
    output logic                                         smp_ready_o,
    input  logic                                         smp_last_i,
    input  logic [5:0][SMP_DATA_BITS-1:0]                smp_coef_i,
    input  logic [SMP_DATA_BITS-1:0]                     smp_resid_i,
    output logic                                         comp_init_o,
    input  logic                                         comp_done_i,
    output logic [5:0][6:0][COMP_DATA_BITS-1:0]          comp_data_o,
    output logic [SMP_CNT_BITS-1:0]                      smp_cnt_o,
    output logic                                         blk_done_o
);

    bld_state_t                  r_state;
    logic                        r_mode6;
    logic                        r_drain;
    logic                        r_init;
    logic                        r_blk_done;
    logic [SMP_CNT_BITS-1:0]     r_cnt;

    logic                        w_fire;
    logic                        w_clr;
    logic                        w_mode6;
    logic signed [SMP_DATA_BITS-1:0] w_coef [AME_NUM_PARAM];
    logic signed [SMP_DATA_BITS-1:0] w_resid;
    logic [COMP_DATA_BITS-1:0]   w_acc_a [AME_NUM_TRI];
    logic [COMP_DATA_BITS-1:0]   w_acc_b [AME_NUM_PARAM];

    assign smp_ready_o = ~rst_i & ((r_state == IDLE) | (r_state == ACCUM));
    assign w_fire      = smp_valid_i & smp_ready_o;
    assign w_clr       = (r_state == WAIT) & comp_done_i;
    // The first sample of a block must already use its own mode, before it is latched.
    assign w_mode6     = (r_state == IDLE) ? affine_param6_i : r_mode6;
    assign w_resid     = $signed(smp_resid_i);

    assign comp_init_o = r_init;
    assign blk_done_o  = r_blk_done;
    assign smp_cnt_o   = r_cnt;

    generate
        for (genvar gi = 0; gi < AME_NUM_PARAM; gi++) begin : g_coef
            if (gi < 2) begin : g_tx
                assign w_coef[gi] = w_mode6 ? $signed(smp_coef_i[gi]) : '0;
            end else begin : g_lin
                assign w_coef[gi] = $signed(smp_coef_i[gi]);
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < AME_NUM_PARAM; gi++) begin : g_row
            for (genvar gj = gi; gj < AME_NUM_PARAM; gj++) begin : g_col
                localparam int SLOT = tri_slot(gi, gj);
                ame_mac_cell #(
                    .SMP_DATA_BITS (SMP_DATA_BITS),
                    .COMP_DATA_BITS(COMP_DATA_BITS)
                ) u_mac_a (
                    .i_clk(clk_i),
                    .i_rst(rst_i),
                    .i_en (w_fire),
                    .i_clr(w_clr),
                    .i_a  (w_coef[gi]),
                    .i_b  (w_coef[gj]),
                    .o_acc(w_acc_a[SLOT])
                );
            end

            ame_mac_cell #(
                .SMP_DATA_BITS (SMP_DATA_BITS),
                .COMP_DATA_BITS(COMP_DATA_BITS)
            ) u_mac_b (
                .i_clk(clk_i),
                .i_rst(rst_i),
                .i_en (w_fire),
                .i_clr(w_clr),
                .i_a  (w_coef[gi]),
                .i_b  (w_resid),
                .o_acc(w_acc_b[gi])
            );
        end
    endgenerate

    // Lower triangle reads the same slot as its upper mirror, so A is exactly symmetric.
    generate
        for (genvar gi = 0; gi < AME_NUM_PARAM; gi++) begin : g_out_row
            for (genvar gj = 0; gj < AME_NUM_PARAM; gj++) begin : g_out_col
                assign comp_data_o[gi][gj] = w_acc_a[tri_slot(gi, gj)];
            end
            assign comp_data_o[gi][AME_NUM_COL-1] = w_acc_b[gi];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_mode6    <= 1'b0;
            r_drain    <= 1'b0;
            r_init     <= 1'b0;
            r_blk_done <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_init     <= 1'b0;
            r_blk_done <= 1'b0;
            if (w_fire && (r_cnt != {SMP_CNT_BITS{1'b1}})) begin
                r_cnt <= r_cnt + SMP_CNT_BITS'(1);
            end
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_mode6 <= affine_param6_i;
                        r_state <= smp_last_i ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_fire && smp_last_i) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Two cycles let the last product reach its accumulator.
                    if (r_drain) begin
                        r_drain <= 1'b0;
                        r_init  <= 1'b1;
                        r_state <= ISSUE;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (comp_done_i) begin
                        r_blk_done <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ame_equation_builder.sv
// Directed bench for ame_equation_builder: a 64-bit instance plus a 32-bit,
// 2-bit-counter instance sharing stimulus for the wrap and saturation cases.
module tb_ame_equation_builder;

    logic                   clk;
    logic                   rst;
    logic                   mode;
    logic                   valid;
    logic                   last;
    logic [5:0][15:0]       coef;
    logic [15:0]            resid;
    logic                   done;

    logic                   ready64;
    logic                   init64;
    logic [5:0][6:0][63:0]  data64;
    logic [15:0]            cnt64;
    logic                   bdone64;

    logic                   ready32;
    logic                   init32;
    logic [5:0][6:0][31:0]  data32;
    logic [1:0]             cnt32;
    logic                   bdone32;

    int     n_checks;
    int     n_fail;
    longint m [6][7];
    bit     m_empty;
    bit     m_mode;

    ame_equation_builder #(
        .SMP_DATA_BITS(16), .COMP_DATA_BITS(64), .SMP_CNT_BITS(16)
    ) u_dut64 (
        .clk_i(clk), .rst_i(rst), .affine_param6_i(mode),
        .smp_valid_i(valid), .smp_ready_o(ready64), .smp_last_i(last),
        .smp_coef_i(coef), .smp_resid_i(resid),
        .comp_init_o(init64), .comp_done_i(done), .comp_data_o(data64),
        .smp_cnt_o(cnt64), .blk_done_o(bdone64)
    );

    ame_equation_builder #(
        .SMP_DATA_BITS(16), .COMP_DATA_BITS(32), .SMP_CNT_BITS(2)
    ) u_dut32 (
        .clk_i(clk), .rst_i(rst), .affine_param6_i(mode),
        .smp_valid_i(valid), .smp_ready_o(ready32), .smp_last_i(last),
        .smp_coef_i(coef), .smp_resid_i(resid),
        .comp_init_o(init32), .comp_done_i(done), .comp_data_o(data32),
        .smp_cnt_o(cnt32), .blk_done_o(bdone32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
                m[i][j] = 0;
        m_empty = 1'b1;
    endtask

    task automatic check_matrix(input string tag);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
                chk($sformatf("%s_m%0d%0d", tag, i, j), data64[i][j], m[i][j]);
    endtask

    task automatic send(input int c0, input int c1, input int c2, input int c3,
                        input int c4, input int c5, input int r,
                        input bit last_i, input bit mode_i);
        int c [6];
        int n;
        c = '{c0, c1, c2, c3, c4, c5};
        @(negedge clk);
        for (int k = 0; k < 6; k++) coef[k] = 16'(c[k]);
        resid = 16'(r);
        last  = last_i;
        mode  = mode_i;
        valid = 1'b1;
        n = 0;
        while (!ready64 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", ready64, 1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        last  = 1'b0;
        if (m_empty) m_mode = mode_i;
        m_empty = 1'b0;
        if (!m_mode) begin
            c[0] = 0;
            c[1] = 0;
        end
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++)
                m[i][j] += longint'(c[i]) * longint'(c[j]);
            m[i][6] += longint'(c[i]) * longint'(r);
        end
    endtask

    // Called right after the last-sample transfer edge; ends in WAIT.
    task automatic check_latency(input string tag);
        chk({tag, "_init_p1"}, init64, 0);
        chk({tag, "_rdy_drain"}, ready64, 0);
        @(posedge clk); #1;
        chk({tag, "_init_p2"}, init64, 0);
        @(posedge clk); #1;
        chk({tag, "_init_p3"}, init64, 1);
        chk({tag, "_rdy_issue"}, ready64, 0);
        @(posedge clk); #1;
        chk({tag, "_init_p4"}, init64, 0);
        chk({tag, "_rdy_wait"}, ready64, 0);
    endtask

    task automatic finish_block(input string tag);
        @(negedge clk);
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        chk({tag, "_bdone"}, bdone64, 1);
        chk({tag, "_cnt_clr"}, cnt64, 0);
        chk({tag, "_rdy_idle"}, ready64, 1);
        model_clear();
        check_matrix({tag, "_clr"});
        @(posedge clk); #1;
        chk({tag, "_bdone_off"}, bdone64, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_clear();
        m_mode = 1'b1;
        rst   = 1'b1;
        mode  = 1'b1;
        valid = 1'b0;
        last  = 1'b0;
        coef  = '0;
        resid = '0;
        done  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", ready64, 0);
        chk("rst_init", init64, 0);
        chk("rst_cnt", cnt64, 0);
        chk("rst_bdone", bdone64, 0);
        chk("rst_b5", data64[5][6], 0);
        rst = 1'b0;
        #1;
        chk("rst_ready_after", ready64, 1);

        // Single sample, 6-param
        send(1, 2, 3, 4, 5, 6, 7, 1'b1, 1'b1);
        chk("t1_cnt", cnt64, 1);
        check_latency("t1");
        chk("t1_A25", data64[2][5], 18);
        chk("t1_A52", data64[5][2], 18);
        chk("t1_A55", data64[5][5], 36);
        chk("t1_B5", data64[5][6], 42);
        chk("t1_B0", data64[0][6], 7);
        check_matrix("t1");
        finish_block("t1");

        // Two samples with negative values
        send(-1, 0, 2, -3, 1, 0, -4, 1'b0, 1'b1);
        send(1, 1, 1, 1, 1, 1, 2, 1'b1, 1'b1);
        chk("t2_cnt", cnt64, 2);
        check_latency("t2");
        chk("t2_A03", data64[0][3], 4);
        chk("t2_A30", data64[3][0], 4);
        chk("t2_A33", data64[3][3], 10);
        chk("t2_B3", data64[3][6], 14);
        chk("t2_B0", data64[0][6], 6);
        check_matrix("t2");
        finish_block("t2");

        // 4-param mode latched on first sample; second sample's mode bit is ignored
        send(9, 9, 1, 2, 3, 4, 5, 1'b0, 1'b0);
        send(9, 9, 1, 2, 3, 4, 5, 1'b1, 1'b1);
        check_latency("t3");
        chk("t3_A00", data64[0][0], 0);
        chk("t3_A12", data64[1][2], 0);
        chk("t3_A21", data64[2][1], 0);
        chk("t3_B0", data64[0][6], 0);
        chk("t3_A23", data64[2][3], 4);
        chk("t3_B5", data64[5][6], 40);
        check_matrix("t3");
        finish_block("t3");

        // comp_done_i during ACCUM is ignored
        send(1, 2, 3, 4, 5, 6, 7, 1'b0, 1'b1);
        @(negedge clk);
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        chk("t4_bdone_ignored", bdone64, 0);
        chk("t4_rdy_accum", ready64, 1);
        chk("t4_cnt_kept", cnt64, 1);
        chk("t4_A55_kept", data64[5][5], 36);
        send(1, 0, 0, 0, 0, 0, 1, 1'b1, 1'b1);
        check_latency("t4");
        chk("t4_A00", data64[0][0], 2);
        check_matrix("t4");
        finish_block("t4");

        // Wrap in a 32-bit accumulator and counter saturation in the 2-bit counter
        send(0, 0, 0, 0, 0, -32768, 0, 1'b0, 1'b1);
        send(0, 0, 0, 0, 0, -32768, 0, 1'b0, 1'b1);
        send(0, 0, 0, 0, 0, -32768, 0, 1'b0, 1'b1);
        chk("t5_cnt32_3", cnt32, 3);
        send(0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
        chk("t5_cnt32_sat", cnt32, 3);
        chk("t5_cnt64", cnt64, 4);
        check_latency("t5");
        chk("t5_A55_w32", data32[5][5], 64'hC000_0000);
        chk("t5_A55_w64", data64[5][5], 64'h0000_0000_C000_0000);
        finish_block("t5");

        // Reset in ACCUM discards the block
        send(1, 2, 3, 4, 5, 6, 7, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_acc_A55", data64[5][5], 0);
        chk("t6_rst_acc_cnt", cnt64, 0);
        chk("t6_rst_acc_rdy", ready64, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("t6_no_init_%0d", k), init64, 0);
        end
        chk("t6_rdy_after", ready64, 1);

        // Reset in WAIT, then a clean block
        send(2, 0, 0, 0, 0, 3, 1, 1'b1, 1'b1);
        check_latency("t7");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t7_rst_wait_A00", data64[0][0], 0);
        chk("t7_rst_wait_B5", data64[5][6], 0);
        chk("t7_rst_wait_init", init64, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("t7_no_init_%0d", k), init64, 0);
            chk($sformatf("t7_no_bdone_%0d", k), bdone64, 0);
        end
        send(0, 0, 1, 1, 1, 1, 3, 1'b1, 1'b1);
        check_latency("t8");
        chk("t8_B2", data64[2][6], 3);
        check_matrix("t8");
        finish_block("t8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
